spi_sclk_gen: RTL and testbench

Parametrised SPI serial-clock generator for the DAC/ADC serial links. It replaces the fixed free-running divider with a transaction-based engine. A `start` launches a burst of exactly `num_bits` SCLK periods at a programmable half-period, in any CPOL/CPHA mode. It emits single-cycle shift/sample strobes, aligned to SCLK edges, that the shift-register datapath uses in the `clk_in` domain.

---
 rtl/spi_sclk_gen_pkg.sv | 25 ++
 rtl/spi_sclk_gen_half_period_counter.sv | 36 +++
 rtl/spi_sclk_gen.sv | 180 ++++++++++++++++++
 tb/tb_spi_sclk_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sclk_gen_pkg.sv
// rtl/spi_sclk_gen_pkg.sv - shared state encoding, default widths and strobe helper for spi_sclk_gen
package spi_sclk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        RUN   = 2'd2,
        TRAIL = 2'd3
    } sclk_state_t;

    localparam int SCLK_CNT_W  = 16;
    localparam int SCLK_BITS_W = 6;

    // Returns {shift, sample} for an SCLK edge. With cpha=0 the last trailing
    // edge has no bit left to drive, so it produces no shift.
    function automatic logic [1:0] edge_strobes(input logic leading,
                                                input logic cpha_mode,
                                                input logic final_edge);
        if (cpha_mode) begin
            return leading ? 2'b10 : 2'b01;
        end
        return leading ? 2'b01 : {~final_edge, 1'b0};
    endfunction

endpackage

// File: rtl/spi_sclk_gen_half_period_counter.sv
// rtl/spi_sclk_gen_half_period_counter.sv - free-running 0..limit-1 divider with one-cycle wrap pulse
module half_period_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             wrap
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A limit of 0 behaves as 1 so the wrap still fires every enabled cycle.
    assign wrap = en && ((limit == '0) || (count_q == limit - 1'b1));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - transaction-based SPI SCLK/strobe generator; SPI_SCLK_GEN_CS_EN adds cs_n and TRAIL
module spi_sclk_gen
    import spi_sclk_pkg::*;
#(
    parameter int CNT_W  = SCLK_CNT_W,
    parameter int BITS_W = SCLK_BITS_W
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  half_period,
    input  logic [BITS_W-1:0] num_bits,
    input  logic              cpol,
    input  logic              cpha,
    output logic              sclk,
    output logic              shift_stb,
    output logic              sample_stb,
    output logic              busy,
    output logic              done
`ifdef SPI_SCLK_GEN_CS_EN
    ,
    output logic              cs_n
`endif
);

    localparam int EDGE_W = BITS_W + 1;

    sclk_state_t       state_q, state_d;
    logic              sclk_q, sclk_d;
    logic              shift_q, shift_d;
    logic              sample_q, sample_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  h_q, h_d;
    logic [BITS_W-1:0] n_q, n_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [EDGE_W-1:0] edge_q, edge_d;

    logic              ctr_clr;
    logic              ctr_en;
    logic              wrap;
    logic [EDGE_W-1:0] last_edge;
    logic [EDGE_W-1:0] edge_next;
    logic [1:0]        stb;

    assign last_edge = {n_q, 1'b0};
    assign edge_next = edge_q + 1'b1;
    assign stb       = edge_strobes(edge_next[0], cpha_q, edge_next == last_edge);

    half_period_counter #(.CNT_W(CNT_W)) u_div (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .limit   (h_q),
        .wrap    (wrap)
    );

    always_comb begin
        state_d  = state_q;
        sclk_d   = sclk_q;
        shift_d  = 1'b0;
        sample_d = 1'b0;
        done_d   = 1'b0;
        h_d      = h_q;
        n_d      = n_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        edge_d   = edge_q;
        ctr_clr  = 1'b0;
        ctr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d  = cpol;
                ctr_clr = 1'b1;
                edge_d  = '0;
                if (start && !abort) begin
                    state_d = LEAD;
                    h_d     = (half_period == '0) ? CNT_W'(1) : half_period;
                    n_d     = (num_bits == '0) ? BITS_W'(1) : num_bits;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    shift_d = ~cpha;
                end
            end
            LEAD: begin
                ctr_en = 1'b1;
                if (wrap) begin
                    state_d  = RUN;
                    sclk_d   = ~sclk_q;
                    edge_d   = edge_next;
                    shift_d  = stb[1];
                    sample_d = stb[0];
                end
            end
            RUN: begin
                ctr_en = 1'b1;
`ifdef SPI_SCLK_GEN_CS_EN
                if (wrap) begin
                    sclk_d   = ~sclk_q;
                    edge_d   = edge_next;
                    shift_d  = stb[1];
                    sample_d = stb[0];
                    if (edge_next == last_edge) begin
                        state_d = TRAIL;
                    end
                end
`else
                // Without a trailing half-period, finish one cycle after the final edge.
                if (edge_q == last_edge) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (wrap) begin
                    sclk_d   = ~sclk_q;
                    edge_d   = edge_next;
                    shift_d  = stb[1];
                    sample_d = stb[0];
                end
`endif
            end
            TRAIL: begin
                ctr_en = 1'b1;
                if (wrap) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            sclk_d   = cpol_q;
            shift_d  = 1'b0;
            sample_d = 1'b0;
            done_d   = 1'b0;
            ctr_clr  = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sclk_q   <= 1'b0;
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
            h_q      <= CNT_W'(1);
            n_q      <= BITS_W'(1);
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            edge_q   <= '0;
        end else begin
            state_q  <= state_d;
            sclk_q   <= sclk_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            done_q   <= done_d;
            h_q      <= h_d;
            n_q      <= n_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            edge_q   <= edge_d;
        end
    end

    assign sclk       = sclk_q;
    assign shift_stb  = shift_q;
    assign sample_stb = sample_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);
`ifdef SPI_SCLK_GEN_CS_EN
    assign cs_n       = (state_q == IDLE);
`endif

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb/tb_spi_sclk_gen.sv - directed self-checking bench for spi_sclk_gen (cs_n checks with SPI_SCLK_GEN_CS_EN)
module tb_spi_sclk_gen;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] half_period;
    logic [5:0]  num_bits;
    logic        cpol;
    logic        cpha;
    logic        sclk;
    logic        shift_stb;
    logic        sample_stb;
    logic        busy;
    logic        done;
    logic        cs_n;

    int n_tests = 0;
    int n_fail  = 0;

    int m_idle, m_edges, m_first, m_last, m_dir, m_shift, m_sample, m_bad;
    int m_done, m_done_cnt, m_sclk_done, m_busy1, m_busy_done, m_csn1, m_csn_done;

    spi_sclk_gen dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .half_period (half_period),
        .num_bits    (num_bits),
        .cpol        (cpol),
        .cpha        (cpha),
        .sclk        (sclk),
        .shift_stb   (shift_stb),
        .sample_stb  (sample_stb),
        .busy        (busy),
        .done        (done)
`ifdef SPI_SCLK_GEN_CS_EN
        ,
        .cs_n        (cs_n)
`endif
    );

`ifndef SPI_SCLK_GEN_CS_EN
    assign cs_n = ~busy;
`endif

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_done_cycle(input int h, input int n);
`ifdef SPI_SCLK_GEN_CS_EN
        return 1 + (2 * n + 1) * h;
`else
        return 2 + 2 * n * h;
`endif
    endfunction

    // Cycle c is the interval after clock edge c-1; edge 0 samples start.
    task automatic do_burst(input int h, input int n, input logic pol, input logic pha, input int limit);
        logic prev;
        logic edge_now;
        half_period = 16'(h);
        num_bits    = 6'(n);
        cpol        = pol;
        cpha        = pha;
        @(negedge clk_in);
        @(negedge clk_in);
        m_idle = int'(sclk);
        prev   = sclk;
        m_edges = 0; m_first = -1; m_last = -1; m_dir = -1; m_shift = 0; m_sample = 0; m_bad = 0;
        m_done = -1; m_done_cnt = 0; m_sclk_done = -1; m_busy1 = -1; m_busy_done = -1;
        m_csn1 = -1; m_csn_done = -1;
        start = 1'b1;
        @(posedge clk_in);
        #1 start = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk_in);
            if (c == 1) begin
                m_busy1 = int'(busy);
                m_csn1  = int'(cs_n);
            end
            edge_now = (sclk != prev);
            if (edge_now) begin
                m_edges++;
                if (m_first < 0) begin
                    m_first = c;
                    m_dir   = int'(sclk);
                end
                m_last = c;
            end
            if (shift_stb) begin
                m_shift++;
                if (!((c == 1 && !pha) || (edge_now && (((m_edges % 2) == 0) == !pha)))) m_bad++;
            end
            if (sample_stb) begin
                m_sample++;
                if (!(edge_now && (((m_edges % 2) == 1) == !pha))) m_bad++;
            end
            if (done) begin
                m_done_cnt++;
                if (m_done < 0) begin
                    m_done      = c;
                    m_sclk_done = int'(sclk);
                    m_busy_done = int'(busy);
                    m_csn_done  = int'(cs_n);
                end
                if (shift_stb || sample_stb) m_bad++;
            end
            prev = sclk;
            if (m_done >= 0 && c >= m_done + 2) break;
        end
    endtask

    task automatic check_burst(input string pfx, input int h, input int n, input logic pol, input logic pha);
        int he;
        int ne;
        he = (h == 0) ? 1 : h;
        ne = (n == 0) ? 1 : n;
        do_burst(h, n, pol, pha, exp_done_cycle(he, ne) + 10);
        check_eq({pfx, "_idle_sclk"}, m_idle, int'(pol));
        check_eq({pfx, "_busy_c1"}, m_busy1, 1);
        check_eq({pfx, "_edges"}, m_edges, 2 * ne);
        check_eq({pfx, "_first_edge"}, m_first, 1 + he);
        check_eq({pfx, "_last_edge"}, m_last, 1 + 2 * ne * he);
        check_eq({pfx, "_first_dir"}, m_dir, int'(!pol));
        check_eq({pfx, "_shifts"}, m_shift, ne);
        check_eq({pfx, "_samples"}, m_sample, ne);
        check_eq({pfx, "_strobe_align"}, m_bad, 0);
        check_eq({pfx, "_done_cycle"}, m_done, exp_done_cycle(he, ne));
        check_eq({pfx, "_done_count"}, m_done_cnt, 1);
        check_eq({pfx, "_sclk_at_done"}, m_sclk_done, int'(pol));
        check_eq({pfx, "_busy_at_done"}, m_busy_done, 0);
`ifdef SPI_SCLK_GEN_CS_EN
        check_eq({pfx, "_csn_c1"}, m_csn1, 0);
        check_eq({pfx, "_csn_at_done"}, m_csn_done, 1);
`endif
    endtask

    initial begin
        int cnt;
        int edges;
        int last_e;
        int done_c;
        int dones;
        int early_idle;
        int second_first;
        logic prev;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        half_period = '0; num_bits = '0; cpol = 1'b1; cpha = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check_eq("rst_sclk", int'(sclk), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_shift", int'(shift_stb), 0);
        check_eq("rst_sample", int'(sample_stb), 0);
        check_eq("rst_csn", int'(cs_n), 1);
        @(negedge clk_in);
        reset_n = 1'b1;

        check_burst("mode0", 1, 8, 1'b0, 1'b0);
        check_burst("mode3", 3, 4, 1'b1, 1'b1);
        check_burst("clamp", 0, 0, 1'b0, 1'b0);
        check_burst("mode1", 2, 5, 1'b0, 1'b1);

        // Abort mid-burst: H=2, N=8, cpol=1, asserted during cycle 10.
        half_period = 16'd2; num_bits = 6'd8; cpol = 1'b1; cpha = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        start = 1'b1;
        @(posedge clk_in);
        #1 start = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clk_in);
        abort = 1'b1;
        @(negedge clk_in);
        abort = 1'b0;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_sclk", int'(sclk), 1);
        check_eq("abort_csn", int'(cs_n), 1);
        cnt = int'(shift_stb) + int'(sample_stb) + int'(done);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            cnt += int'(shift_stb) + int'(sample_stb) + int'(done);
        end
        check_eq("abort_quiet", cnt, 0);

        // start held through an H=1, N=2 burst; half_period changed after acceptance.
        half_period = 16'd1; num_bits = 6'd2; cpol = 1'b0; cpha = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        prev = sclk;
        start = 1'b1;
        @(posedge clk_in);
        #1 half_period = 16'd5;
        edges = 0; last_e = -1; done_c = -1; dones = 0; early_idle = 0; second_first = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk_in);
            if (sclk != prev) begin
                if (c <= 6) begin
                    edges++;
                    last_e = c;
                end else if (second_first < 0) begin
                    second_first = c;
                end
            end
            prev = sclk;
            if (c < 6 && !busy) early_idle++;
            if (c == 7) begin
                check_eq("hold_busy_c7", int'(busy), 1);
                check_eq("hold_preload_c7", int'(shift_stb), 1);
                start = 1'b0;
            end
            if (done) begin
                dones++;
                if (dones == 1) done_c = c;
                if (dones == 2) begin
                    check_eq("hold_second_done", c, 6 + exp_done_cycle(5, 2));
                    break;
                end
            end
        end
        check_eq("hold_edges", edges, 4);
        check_eq("hold_last_edge", last_e, 5);
        check_eq("hold_done", done_c, 6);
        check_eq("hold_busy_gap", early_idle, 0);
        check_eq("hold_second_first", second_first, 12);
        check_eq("hold_done_count", dones, 2);

        // Asynchronous reset during cycle 7 of an H=2, N=4 mode-3 burst.
        half_period = 16'd2; num_bits = 6'd4; cpol = 1'b1; cpha = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        start = 1'b1;
        @(posedge clk_in);
        #1 start = 1'b0;
        for (int c = 1; c <= 7; c++) @(negedge clk_in);
        #1 reset_n = 1'b0;
        #1;
        check_eq("arst_sclk", int'(sclk), 0);
        check_eq("arst_busy", int'(busy), 0);
        check_eq("arst_csn", int'(cs_n), 1);
        check_eq("arst_strobes", int'(shift_stb) + int'(sample_stb) + int'(done), 0);
        @(negedge clk_in);
        reset_n = 1'b1;
        check_burst("after_rst", 2, 4, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
